arb_req_agent: RTL

- Client-side agent for the 8-way round-robin bus arbiter. It queues burst commands and raises one request line. It watches the arbiter's one-hot select for its own bit.
- It holds the arbiter's lock line for the whole burst, so ownership cannot rotate mid-transfer.
- It then runs the burst on the shared bus and releases the lock.
- One instance per bus master. Its req/lock drive bit ID of the arbiter's req[7:0]/lock[7:0].

---
 rtl/arb_req_agent.sv | 138 +++++++++++++
 1 files changed

// File: rtl/arb_req_agent.sv
// rtl/arb_req_agent.sv - round-robin arbiter client: command FIFO, req/lock handshake, burst engine
// Define ARB_REQ_AGENT_CHAIN_EN to run up to four queued bursts back-to-back under one lock.
module arb_req_agent #(
   parameter int ID    = 0,
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_adr,
   input  logic [2:0]    cmd_len,
   output logic          req,
   output logic          lock,
   input  logic [7:0]    sel,
   output logic          bus_cyc,
   output logic          bus_stb,
   output logic [AW-1:0] bus_adr,
   input  logic          bus_ack,
   output logic          done,
   output logic          grant_err
);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

   state_t        state;
   logic [AW-1:0] adr_mem [DEPTH];
   logic [2:0]    len_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic [2:0]    beat;
   logic [AW-1:0] head_adr;
   logic [2:0]    head_len;
   logic          push;
   logic          pop;
   logic          granted;
   logic          last_ack;
   logic          chain_go;
   logic          unused_sel;

   assign unused_sel = ^sel;
   assign granted    = sel[ID];
   assign head_adr   = adr_mem[rd_ptr];
   assign head_len   = len_mem[rd_ptr];
   assign cmd_ready  = (count != (PW+1)'(DEPTH));
   assign push       = cmd_valid & cmd_ready;
   assign last_ack   = (state == XFER) & bus_ack & (beat == head_len);
   assign pop        = last_ack;

`ifdef ARB_REQ_AGENT_CHAIN_EN
   logic [1:0] chain_cnt;
   // Chain only if a command remains once the head is popped (a same-cycle push counts).
   assign chain_go = last_ack & ((count > (PW+1)'(1)) | push) & (chain_cnt != 2'd3);
`else
   assign chain_go = 1'b0;
`endif

   assign req     = (state == REQ) | (state == XFER);
   assign lock    = ((state == REQ) & granted) | ((state == XFER) & ~(last_ack & ~chain_go));
   assign bus_cyc = (state == XFER);
   assign bus_stb = (state == XFER);
   assign bus_adr = (state == XFER) ? head_adr + AW'({beat, 2'b00}) : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         adr_mem[wr_ptr] <= cmd_adr;
         len_mem[wr_ptr] <= cmd_len;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         beat      <= '0;
         done      <= 1'b0;
         grant_err <= 1'b0;
`ifdef ARB_REQ_AGENT_CHAIN_EN
         chain_cnt <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if ((count != '0) | push) state <= REQ;
            end
            REQ: begin
               if (granted) begin
                  state <= XFER;
                  beat  <= '0;
               end
            end
            XFER: begin
               if (!granted) grant_err <= 1'b1;
               if (bus_ack) begin
                  beat <= beat + 1'b1;
                  if (beat == head_len) begin
                     done <= 1'b1;
                     if (chain_go) begin
                        beat <= '0;
`ifdef ARB_REQ_AGENT_CHAIN_EN
                        chain_cnt <= chain_cnt + 1'b1;
`endif
                     end else begin
                        state <= GAP;
`ifdef ARB_REQ_AGENT_CHAIN_EN
                        chain_cnt <= '0;
`endif
                     end
                  end
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
